// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_pkg
// Description : Shared router definitions: field widths, TX state encoding and
//               header packing used by the packet source and router checkers.
// Revision    : 1.0
// ============================================================================
package router_pkg;

    localparam int ADDR_W   = 2;
    localparam int LEN_W    = 6;
    localparam int DATA_W   = 8;
    localparam int MAX_DEST = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_PARITY  = 3'd3,
        ST_GAP     = 3'd4
    } tx_state_t;

    // Header byte layout: length in the upper bits, destination in the low bits.
    function automatic logic [DATA_W-1:0] hdr_pack(input logic [LEN_W-1:0]  len,
                                                   input logic [ADDR_W-1:0] dest);
        return {len, dest};
    endfunction

endpackage
`default_nettype wire

// File: rtl/router_tx_buf.sv
`default_nettype none
// ============================================================================
// Module      : router_tx_buf
// Description : Synchronous show-ahead FIFO for payload bytes with count,
//               full and empty status. Writes while full are dropped.
// Revision    : 1.0
// ============================================================================
module router_tx_buf #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_CNT_W = c_AW + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign w_push = i_wr_en && !o_full;
    assign w_pop  = i_rd_en && !o_empty;

    // Storage is left unreset so it can map onto RAM; pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_full    = (r_count == c_CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/router_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module      : router_pkt_tx
// Description : Router input-port packet source. Buffers payload bytes, then
//               sends header, payload and parity, holding each byte on busy.
//               Optional macro PKT_TX_ERR_INJECT_EN adds inject_err, which
//               inverts the parity byte of the packet it is started with.
// Revision    : 1.0
// ============================================================================
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int GAP_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     buf_wr_en,
    input  logic [DATA_W-1:0]        buf_wr_data,
    output logic                     buf_full,
    output logic [$clog2(DEPTH):0]   buf_count,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        dest,
    input  logic [LEN_W-1:0]         len,
    output logic                     ready,
    output logic                     start_err,
    input  logic                     busy,
    output logic                     pkt_valid,
    output logic [DATA_W-1:0]        data_out,
`ifdef PKT_TX_ERR_INJECT_EN
    input  logic                     inject_err,
`endif
    output logic                     done
);

    localparam int c_CNT_W = $clog2(DEPTH) + 1;
    localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    tx_state_t          r_state;
    tx_state_t          w_state_nxt;
    logic [ADDR_W-1:0]  r_dest;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_rem;
    logic [DATA_W-1:0]  r_parity;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic               r_done;
    logic               r_start_err;
    logic [DATA_W-1:0]  w_fifo_head;
    logic               w_fifo_empty;
    logic               w_pop;
    logic               w_start_ok;
    logic               w_gap_last;
    logic [DATA_W-1:0]  w_parity_out;

    router_tx_buf #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (buf_wr_en),
        .i_wr_data (buf_wr_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_fifo_head),
        .o_count   (buf_count),
        .o_full    (buf_full),
        .o_empty   (w_fifo_empty)
    );

    // Only bytes already buffered at start time may back the packet.
    assign w_start_ok = (dest <= ADDR_W'(MAX_DEST)) && (len != '0) &&
                        (buf_count >= c_CNT_W'(len));
    assign w_gap_last = (r_gap_cnt == c_GAP_W'(GAP_CYCLES - 1));

`ifdef PKT_TX_ERR_INJECT_EN
    logic r_inj;
    assign w_parity_out = r_inj ? ~r_parity : r_parity;
`else
    assign w_parity_out = r_parity;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Outputs depend on state and held registers only, so busy never reaches them.
    always_comb begin
        w_state_nxt = r_state;
        pkt_valid   = 1'b0;
        data_out    = '0;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && w_start_ok) begin
                    w_state_nxt = ST_HEADER;
                end
            end
            ST_HEADER: begin
                pkt_valid = 1'b1;
                data_out  = hdr_pack(r_len, r_dest);
                if (!busy) begin
                    w_state_nxt = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                pkt_valid = 1'b1;
                data_out  = w_fifo_head;
                if (!busy && !w_fifo_empty) begin
                    w_pop = 1'b1;
                    if (r_rem == LEN_W'(1)) begin
                        w_state_nxt = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                data_out = w_parity_out;
                if (!busy) begin
                    w_state_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_gap_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dest      <= '0;
            r_len       <= '0;
            r_rem       <= '0;
            r_parity    <= '0;
            r_gap_cnt   <= '0;
            r_done      <= 1'b0;
            r_start_err <= 1'b0;
`ifdef PKT_TX_ERR_INJECT_EN
            r_inj       <= 1'b0;
`endif
        end else begin
            r_done      <= 1'b0;
            r_start_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_start_ok) begin
                            r_dest   <= dest;
                            r_len    <= len;
                            r_rem    <= len;
                            r_parity <= hdr_pack(len, dest);
`ifdef PKT_TX_ERR_INJECT_EN
                            r_inj    <= inject_err;
`endif
                        end else begin
                            r_start_err <= 1'b1;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (w_pop) begin
                        r_parity <= r_parity ^ w_fifo_head;
                        r_rem    <= r_rem - 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (!busy) begin
                        r_done    <= 1'b1;
                        r_gap_cnt <= '0;
                    end
                end
                ST_GAP: begin
                    r_gap_cnt <= r_gap_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign ready     = (r_state == ST_IDLE);
    assign done      = r_done;
    assign start_err = r_start_err;

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_pkt_tx
// Description : Self-checking bench for router_pkt_tx using per-cycle vector
//               tables and directed multi-cycle sequences.
// Revision    : 1.0
// ============================================================================
module tb_router_pkt_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       buf_wr_en = 1'b0;
    logic [7:0] buf_wr_data = 8'h00;
    logic       buf_full;
    logic [6:0] buf_count;
    logic       start = 1'b0;
    logic [1:0] dest = 2'd0;
    logic [5:0] len = 6'd0;
    logic       ready;
    logic       start_err;
    logic       busy = 1'b0;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       done;
`ifdef PKT_TX_ERR_INJECT_EN
    logic       inject_err = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    router_pkt_tx #(.DEPTH(64), .GAP_CYCLES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .buf_wr_en   (buf_wr_en),
        .buf_wr_data (buf_wr_data),
        .buf_full    (buf_full),
        .buf_count   (buf_count),
        .start       (start),
        .dest        (dest),
        .len         (len),
        .ready       (ready),
        .start_err   (start_err),
        .busy        (busy),
        .pkt_valid   (pkt_valid),
        .data_out    (data_out),
`ifdef PKT_TX_ERR_INJECT_EN
        .inject_err  (inject_err),
`endif
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       busy;
        logic       pv;
        logic [7:0] data;
        logic       done;
        logic       ready;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic addv(input logic b, input logic pv, input logic [7:0] d,
                        input logic dn, input logic rd);
        vec_t v;
        v.busy = b; v.pv = pv; v.data = d; v.done = dn; v.ready = rd;
        vecs.push_back(v);
    endtask

    // Check the current cycle's outputs, then drive busy for the coming edge.
    task automatic play(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            chk($sformatf("vec%0d.pkt_valid", i), 32'(pkt_valid), 32'(vecs[i].pv));
            chk($sformatf("vec%0d.data_out", i), 32'(data_out), 32'(vecs[i].data));
            chk($sformatf("vec%0d.done", i), 32'(done), 32'(vecs[i].done));
            chk($sformatf("vec%0d.ready", i), 32'(ready), 32'(vecs[i].ready));
            busy = vecs[i].busy;
            tick();
        end
        busy = 1'b0;
    endtask

    task automatic wr(input logic [7:0] b);
        buf_wr_en   = 1'b1;
        buf_wr_data = b;
        tick();
        buf_wr_en   = 1'b0;
    endtask

    task automatic do_start(input logic [1:0] d, input logic [5:0] l, input logic inj);
        dest  = d;
        len   = l;
        start = 1'b1;
`ifdef PKT_TX_ERR_INJECT_EN
        inject_err = inj;
`else
        if (inj) $display("inject request ignored in this build");
`endif
        tick();
        start = 1'b0;
`ifdef PKT_TX_ERR_INJECT_EN
        inject_err = 1'b0;
`endif
    endtask

    task automatic reject(input string name, input logic [1:0] d, input logic [5:0] l);
        do_start(d, l, 1'b0);
        chk({name, ".start_err"}, 32'(start_err), 32'd1);
        chk({name, ".ready"}, 32'(ready), 32'd1);
        chk({name, ".pkt_valid"}, 32'(pkt_valid), 32'd0);
        tick();
        chk({name, ".start_err_clr"}, 32'(start_err), 32'd0);
    endtask

    initial begin
        // Packet 1 (dest=1 len=3, no stall): indices 0..7
        addv(0, 1, 8'h0D, 0, 0); addv(0, 1, 8'h03, 0, 0); addv(0, 1, 8'hA5, 0, 0);
        addv(0, 1, 8'h3C, 0, 0); addv(0, 0, 8'h97, 0, 0); addv(0, 0, 8'h00, 1, 0);
        addv(0, 0, 8'h00, 0, 0); addv(0, 0, 8'h00, 0, 1);
        // Same packet, A5 stalled four cycles: indices 8..19
        addv(0, 1, 8'h0D, 0, 0); addv(0, 1, 8'h03, 0, 0); addv(1, 1, 8'hA5, 0, 0);
        addv(1, 1, 8'hA5, 0, 0); addv(1, 1, 8'hA5, 0, 0); addv(1, 1, 8'hA5, 0, 0);
        addv(0, 1, 8'hA5, 0, 0); addv(0, 1, 8'h3C, 0, 0); addv(0, 0, 8'h97, 0, 0);
        addv(0, 0, 8'h00, 1, 0); addv(0, 0, 8'h00, 0, 0); addv(0, 0, 8'h00, 0, 1);
        // Injected parity then clean parity: indices 20..27, 28..35
        addv(0, 1, 8'h0D, 0, 0); addv(0, 1, 8'h03, 0, 0); addv(0, 1, 8'hA5, 0, 0);
        addv(0, 1, 8'h3C, 0, 0); addv(0, 0, 8'h68, 0, 0); addv(0, 0, 8'h00, 1, 0);
        addv(0, 0, 8'h00, 0, 0); addv(0, 0, 8'h00, 0, 1);
        addv(0, 1, 8'h0D, 0, 0); addv(0, 1, 8'h03, 0, 0); addv(0, 1, 8'hA5, 0, 0);
        addv(0, 1, 8'h3C, 0, 0); addv(0, 0, 8'h97, 0, 0); addv(0, 0, 8'h00, 1, 0);
        addv(0, 0, 8'h00, 0, 0); addv(0, 0, 8'h00, 0, 1);

        tick(); tick();
        chk("rst.pkt_valid", 32'(pkt_valid), 32'd0);
        chk("rst.data_out", 32'(data_out), 32'd0);
        chk("rst.ready", 32'(ready), 32'd1);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.start_err", 32'(start_err), 32'd0);
        chk("rst.buf_count", 32'(buf_count), 32'd0);
        rst = 1'b0;
        tick();

        wr(8'h03); wr(8'hA5); wr(8'h3C);
        chk("t1.buf_count", 32'(buf_count), 32'd3);
        do_start(2'd1, 6'd3, 1'b0);
        play(0, 7);
        chk("t1.buf_empty", 32'(buf_count), 32'd0);

        wr(8'h03); wr(8'hA5); wr(8'h3C);
        do_start(2'd1, 6'd3, 1'b0);
        play(8, 19);

        wr(8'd0); wr(8'd1); wr(8'd2);
        reject("t3.short", 2'd0, 6'd5);
        reject("t3.dest3", 2'd3, 6'd1);
        reject("t3.len0", 2'd0, 6'd0);
        chk("t3.buf_count", 32'(buf_count), 32'd3);

        for (int i = 3; i < 64; i++) wr(8'(i));
        chk("t4.full", 32'(buf_full), 32'd1);
        wr(8'hEE);
        chk("t4.count_after_drop", 32'(buf_count), 32'd64);
        do_start(2'd2, 6'd63, 1'b0);
        chk("t4.hdr", 32'(data_out), 32'hFE);
        tick();
        for (int i = 0; i < 63; i++) begin
            chk($sformatf("t4.pay%0d", i), 32'({pkt_valid, data_out}), 32'({1'b1, 8'(i)}));
            tick();
        end
        chk("t4.parity", 32'({pkt_valid, data_out}), 32'h0C1);
        tick();
        chk("t4.done", 32'(done), 32'd1);
        tick(); tick();
        chk("t4.ready", 32'(ready), 32'd1);
        chk("t4.count_left", 32'(buf_count), 32'd1);
        do_start(2'd0, 6'd1, 1'b0);
        chk("t4b.hdr", 32'(data_out), 32'h04);
        tick();
        chk("t4b.pay", 32'({pkt_valid, data_out}), 32'h13F);
        buf_wr_en   = 1'b1;
        buf_wr_data = 8'h77;
        tick();
        buf_wr_en   = 1'b0;
        chk("t4b.push_pop_count", 32'(buf_count), 32'd1);
        chk("t4b.parity", 32'({pkt_valid, data_out}), 32'h03B);
        tick();
        chk("t4b.done", 32'(done), 32'd1);
        tick(); tick();

        for (int i = 0; i < 10; i++) wr(8'h50 + 8'(i));
        do_start(2'd1, 6'd10, 1'b0);
        tick();
        chk("t5.payload_pv", 32'(pkt_valid), 32'd1);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("t5.rst_pv", 32'(pkt_valid), 32'd0);
        chk("t5.rst_data", 32'(data_out), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk("t5.ready", 32'(ready), 32'd1);
        chk("t5.buf_count", 32'(buf_count), 32'd0);
        chk("t5.pv_idle", 32'(pkt_valid), 32'd0);

`ifdef PKT_TX_ERR_INJECT_EN
        wr(8'h03); wr(8'hA5); wr(8'h3C);
        do_start(2'd1, 6'd3, 1'b1);
        play(20, 27);
        wr(8'h03); wr(8'hA5); wr(8'h3C);
        do_start(2'd1, 6'd3, 1'b0);
        play(28, 35);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
